mem_dma: RTL and testbench
==========================

MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of memory address and of the src/dst/len operands.
REQ-002 SHALL have parameter DATA_W, default 8, width of a memory word.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request a transfer; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the transfer in progress.
REQ-007 SHALL have port src  input  ADDR_W  source start address, captured on accepted start.
REQ-008 SHALL have port dst  input  ADDR_W  destination start address, captured on accepted start.
REQ-009 SHALL have port len  input  ADDR_W  word count 0..255, captured on accepted start.
REQ-010 SHALL have port busy  output  1  high in READ and WRITE states.
REQ-011 SHALL have port done  output  1  one-cycle pulse in DONE state.
REQ-012 SHALL have port mem_we  output  1  memory write enable.
REQ-013 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-014 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-015 SHALL have port mem_rdata  input  DATA_W  memory read data, combinational from mem_addr (zero-latency read).

Function
REQ-016 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-017 In IDLE, start=1 at edge k with len>0 SHALL capture src/dst/len and enter READ; with len=0 SHALL enter DONE; no memory access.
REQ-018 READ SHALL drive mem_addr=src+i, mem_we=0, capture mem_rdata into a DATA_W buffer at the closing edge, then enter WRITE.
REQ-019 WRITE SHALL drive mem_addr=dst+i, mem_we=1, mem_wdata=buffer, increment i, then enter READ if words remain, else DONE.
REQ-020 Word i SHALL be read in cycle k+2i and written in cycle k+2i+1; DONE SHALL occupy cycle k+2N; IDLE SHALL resume at k+2N+1.
REQ-021 DONE SHALL last exactly one cycle, then enter IDLE; a start seen at the edge leaving DONE SHALL be ignored.
REQ-022 Address arithmetic SHALL be modulo 2^ADDR_W (255+1 wraps to 0); no error is flagged.
REQ-023 Copy SHALL proceed in ascending address order; overlapping regions SHALL not be specially handled (forward-copy semantics).
REQ-024 start while busy or in DONE SHALL be ignored and SHALL not alter captured operands.
REQ-025 abort=1 at any edge in READ or WRITE SHALL enter IDLE with no done pulse; the write in the cycle where abort is sampled still completes.
REQ-026 abort in IDLE or DONE SHALL have no effect; abort and start together in IDLE: abort wins, no transfer.
REQ-027 Outside WRITE, mem_we SHALL be 0 and mem_wdata SHALL be 0; in IDLE and DONE, mem_addr SHALL be 0.

Reset
REQ-028 rst=1 SHALL immediately, without a clock, force IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, buffer and counter 0.
REQ-029 Reset mid-transfer SHALL abandon it; destination words not yet written remain unchanged.

Configuration
REQ-030 With macro MEM_DMA_FILL_EN defined, SHALL add inputs fill (1) and fill_val (DATA_W), captured on accepted start.
REQ-031 With MEM_DMA_FILL_EN and fill=1, SHALL skip READ: N consecutive WRITE cycles k..k+N-1 writing fill_val to dst+i, DONE at cycle k+N; src ignored.
REQ-032 Without MEM_DMA_FILL_EN, fill and fill_val ports SHALL not exist and only copy mode SHALL be built.

Verification
REQ-033 mem[0x10..0x12]=AA,BB,CC; start src=10 dst=40 len=3 -> mem[0x40..0x42]=AA,BB,CC, done pulse exactly 6 cycles after start edge, busy high 6 cycles.
REQ-034 start len=0 -> done next cycle, mem_we never asserted, busy never asserted.
REQ-035 src=FE dst=00 len=4 with mem[FE,FF,00,01]=1,2,3,4 -> reads wrap FE,FF,00,01; mem[00..03]=1,2,1,2 (forward-overlap semantics).
REQ-036 len=5, abort raised in cycle of word 2 read -> words 0-1 written, word 2 not written, no done, IDLE next cycle.
REQ-037 rst asserted mid-transfer between edges -> outputs 0 immediately; new start after release completes normally.
REQ-038 MEM_DMA_FILL_EN build: fill=1 fill_val=5A dst=80 len=4 -> mem[80..83]=5A, mem_we high 4 consecutive cycles, done at cycle k+4.

Source files
------------

// File: rtl/mem_dma.sv
// mem_dma: memory-to-memory copy engine, one word per READ/WRITE cycle pair.
// Optional constant-fill mode (WRITE-only cycles) is built when MEM_DMA_FILL_EN is defined.
module mem_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
`ifdef MEM_DMA_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_val,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state_o
);

    // Control protocol: start is a level sampled only in IDLE (no ready
    // back-pressure); abort is sampled at every edge but acts only in READ/WRITE
    // and beats a simultaneous start. done is a single-cycle pulse.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              use_fill;
    logic              start_fill;
    logic [DATA_W-1:0] fill_word;
    logic [ADDR_W-1:0] idx_inc;

`ifdef MEM_DMA_FILL_EN
    logic              fill_q, fill_d;
    logic [DATA_W-1:0] fill_val_q, fill_val_d;

    assign use_fill   = fill_q;
    assign start_fill = fill;
    assign fill_word  = fill_val_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else begin
            fill_q     <= fill_d;
            fill_val_q <= fill_val_d;
        end
    end

    always_comb begin
        fill_d     = fill_q;
        fill_val_d = fill_val_q;
        if (state_q == S_IDLE && start && !abort) begin
            fill_d     = fill;
            fill_val_d = fill_val;
        end
    end
`else
    assign use_fill   = 1'b0;
    assign start_fill = 1'b0;
    assign fill_word  = '0;
`endif

    assign idx_inc     = idx_q + ONE;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    src_d = src;
                    dst_d = dst;
                    len_d = len;
                    idx_d = '0;
                    if (len == '0)
                        state_d = S_DONE;
                    else if (start_fill)
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                busy     = 1'b1;
                mem_addr = src_q + idx_q;
                buf_d    = mem_rdata;
                state_d  = abort ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_q + idx_q;
                mem_wdata = use_fill ? fill_word : buf_q;
                idx_d     = idx_inc;
                // The write itself lands at this edge even when abort is sampled.
                if (abort)
                    state_d = S_IDLE;
                else if (idx_inc == len_q)
                    state_d = S_DONE;
                else if (use_fill)
                    state_d = S_WRITE;
                else
                    state_d = S_READ;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// Randomised scoreboard bench for mem_dma: a per-transfer word-level model
// predicts every read, write and done pulse; a negedge monitor checks them.
module tb_mem_dma;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int EW = 32 + AW + DW;
    localparam int RW = 32 + AW;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
`ifdef MEM_DMA_FILL_EN
    logic          fill;
    logic [DW-1:0] fill_val;
`endif
    logic          busy;
    logic          done;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    dbg_state_o;

    mem_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src(src), .dst(dst), .len(len),
`ifdef MEM_DMA_FILL_EN
        .fill(fill), .fill_val(fill_val),
`endif
        .busy(busy), .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset / memory ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem   [256];
    logic [DW-1:0] img   [256];
    logic [DW-1:0] model [256];
    logic          load_en = 1'b0;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [RW-1:0] rd_q[$];
    int            done_q[$];
    int            busy_from = 0;
    int            busy_to   = 0;
    int            n_assert  = 0;
    int            n_fail    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_assert++;
        n_fail++;
        $display("FAIL %s at cycle %0d: unexpected event", nm, cyc);
    endtask

    always @(negedge clk) begin
        logic exp_busy;
        exp_busy = (cyc >= busy_from) && (cyc < busy_to);
        chk("busy", 64'(busy), 64'(exp_busy));
        if (done) begin
            if (done_q.size() == 0) fail_now("done_unexpected");
            else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        end
        if (mem_we) begin
            if (exp_q.size() == 0) fail_now("write_unexpected");
            else chk("write", 64'({32'(cyc), mem_addr, mem_wdata}), 64'(exp_q.pop_front()));
        end else begin
            chk("wdata_zero", 64'(mem_wdata), 64'd0);
            if (busy) begin
                if (rd_q.size() == 0) fail_now("read_unexpected");
                else chk("read", 64'({32'(cyc), mem_addr}), 64'(rd_q.pop_front()));
            end
        end
        if (!busy) chk("addr_idle", 64'(mem_addr), 64'd0);
    end

    // ---------------- driver tasks ----------------
    task automatic load_mem(input bit randomize);
        for (int i = 0; i < 256; i++) begin
            if (randomize) img[i] = DW'($urandom);
            model[i] = img[i];
        end
        @(posedge clk); #1;
        load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic check_mem(input string nm);
        int errs;
        errs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== model[i]) errs++;
        chk(nm, 64'(errs), 64'd0);
    endtask

    // ab_c / rs_c: cycle offset from the start edge at which abort is sampled
    // or reset is asserted (-1 = none). hold keeps start high through DONE.
    task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW-1:0] l, input bit f, input logic [DW-1:0] fv,
                            input int ab_c, input int rs_c, input bit hold);
        int  k, n, t_end, wc, rc;
        bit  aborted, resetted, wr_ok, rd_ok;
        logic [DW-1:0] data;
        logic [AW-1:0] a;
        @(posedge clk); #1;
        src = s; dst = d; len = l; start = 1'b1; abort = 1'b0;
`ifdef MEM_DMA_FILL_EN
        fill = f; fill_val = fv;
`endif
        @(posedge clk); #1;
        k = cyc;
        if (!hold) start = 1'b0;
        src = AW'($urandom); dst = AW'($urandom); len = AW'($urandom);
`ifdef MEM_DMA_FILL_EN
        fill = 1'($urandom); fill_val = DW'($urandom);
`endif
        n = int'(l);
        t_end    = (n == 0) ? 0 : (f ? n : 2 * n);
        aborted  = (ab_c >= 0) && (ab_c < t_end);
        resetted = (rs_c >= 0) && (rs_c < t_end);
        for (int i = 0; i < n; i++) begin
            wc = f ? i : 2 * i + 1;
            rc = 2 * i;
            wr_ok = aborted ? (wc <= ab_c) : (resetted ? (wc < rs_c) : 1'b1);
            rd_ok = aborted ? (rc <= ab_c) : (resetted ? (rc < rs_c) : 1'b1);
            if (!f && rd_ok) begin
                a = s + AW'(i);
                rd_q.push_back({32'(k + rc), a});
            end
            if (wr_ok) begin
                a = s + AW'(i);
                data = f ? fv : model[a];
                a = d + AW'(i);
                model[a] = data;
                exp_q.push_back({32'(k + wc), a, data});
            end
        end
        busy_from = k;
        busy_to   = k + (aborted ? ab_c + 1 : (resetted ? rs_c : t_end));
        if (!aborted && !resetted) done_q.push_back(k + t_end);
        for (int t = 0; t <= t_end; t++) begin
            if (t == ab_c) abort = 1'b1;
            if (resetted && t == rs_c) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                chk("rst_we", 64'(mem_we), 64'd0);
                chk("rst_addr", 64'(mem_addr), 64'd0);
                chk("rst_wdata", 64'(mem_wdata), 64'd0);
                chk("rst_state", 64'(dbg_state_o), 64'd0);
            end
            @(posedge clk); #1;
            abort = 1'b0;
            rst   = 1'b0;
            if (aborted && t == ab_c) begin
                chk("abort_idle", 64'(dbg_state_o), 64'd0);
                break;
            end
            if (resetted && t == rs_c) break;
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("writes_drained", 64'(exp_q.size()), 64'd0);
        chk("reads_drained", 64'(rd_q.size()), 64'd0);
        chk("done_drained", 64'(done_q.size()), 64'd0);
        check_mem("mem_image");
        exp_q.delete();
        rd_q.delete();
        done_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int mode, l, t_len, ab, rs;
        bit f;
        #300000;
        $display("FAIL watchdog at cycle %0d: time limit reached", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, l, t_len, ab, rs, k0;
        bit f;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src = '0; dst = '0; len = '0;
`ifdef MEM_DMA_FILL_EN
        fill = 1'b0; fill_val = '0;
`endif
        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_we", 64'(mem_we), 64'd0);
        chk("reset_addr", 64'(mem_addr), 64'd0);
        chk("reset_state", 64'(dbg_state_o), 64'd0);
        load_mem(1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        // three-word copy
        for (int i = 0; i < 256; i++) img[i] = model[i];
        img[8'h10] = 8'hAA; img[8'h11] = 8'hBB; img[8'h12] = 8'hCC;
        load_mem(1'b0);
        run_xfer(8'h10, 8'h40, 8'd3, 1'b0, 8'h00, -1, -1, 1'b0);

        // zero length, start held through DONE
        run_xfer(8'h20, 8'h30, 8'd0, 1'b0, 8'h00, -1, -1, 1'b1);

        // wrapping, overlapping forward copy
        for (int i = 0; i < 256; i++) img[i] = model[i];
        img[8'hFE] = 8'd1; img[8'hFF] = 8'd2; img[8'h00] = 8'd3; img[8'h01] = 8'd4;
        load_mem(1'b0);
        run_xfer(8'hFE, 8'h00, 8'd4, 1'b0, 8'h00, -1, -1, 1'b0);

        // abort sampled in the read of word 2
        run_xfer(8'h50, 8'h60, 8'd5, 1'b0, 8'h00, 4, -1, 1'b0);

        // reset mid-transfer, then a normal transfer
        run_xfer(8'h70, 8'h90, 8'd6, 1'b0, 8'h00, -1, 5, 1'b0);
        run_xfer(8'h70, 8'h90, 8'd6, 1'b0, 8'h00, -1, -1, 1'b0);

        // abort in DONE has no effect
        run_xfer(8'h05, 8'hA0, 8'd2, 1'b0, 8'h00, 4, -1, 1'b0);

        // abort together with start in IDLE
        @(posedge clk); #1;
        src = 8'h11; dst = 8'h22; len = 8'd3; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", 64'(dbg_state_o), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check_mem("mem_after_abort_start");

`ifdef MEM_DMA_FILL_EN
        run_xfer(8'h33, 8'h80, 8'd4, 1'b1, 8'h5A, -1, -1, 1'b0);
`endif

        for (int r = 0; r < 30; r++) begin
            l = $urandom_range(0, 12);
            f = 1'b0;
`ifdef MEM_DMA_FILL_EN
            f = 1'($urandom_range(0, 1));
`endif
            t_len = (l == 0) ? 0 : (f ? l : 2 * l);
            mode = $urandom_range(0, 3);
            ab = -1; rs = -1;
            if (mode == 2) ab = $urandom_range(0, t_len);
            if (mode == 3 && t_len > 0) rs = $urandom_range(0, t_len - 1);
            run_xfer(AW'($urandom), AW'($urandom), AW'(l), f, DW'($urandom),
                     ab, rs, mode == 1);
        end

        k0 = cyc;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
